irq_controller: RTL

IRQ_CONTROLLER -- requirements
Module: irq_controller

---
 rtl/irq_pkg.sv | 15 +
 rtl/irq_prio_enc.sv | 23 ++
 rtl/irq_controller.sv | 100 ++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types and constants for the external interrupt controller
package irq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } irq_state_e;

   localparam int N_SRC_DEFAULT = 4;

   // Exception status code the core records for an external interrupt
   localparam logic [3:0] ESTATUS_EXT_IRQ = 4'b0001;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - combinational lowest-index-wins priority encoder
module irq_prio_enc #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   output logic [W-1:0] idx,
   output logic         valid
);

   // Scan from the top down so the lowest set index is the last assignment
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - edge-detected, masked, fixed-priority interrupt request to the core
// with a REQ/acknowledge/service handshake; all outputs are registered.
module irq_controller
   import irq_pkg::*;
#(
   parameter int N_SRC = N_SRC_DEFAULT,
   parameter int ID_W  = $clog2(N_SRC)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] irq_src,
   input  logic [N_SRC-1:0] irq_mask,
   input  logic             ExtIAck,
   input  logic             ERet,
   output logic             ExtIRQ,
   output logic [ID_W-1:0]  irq_id,
   output logic [N_SRC-1:0] pending,
   output logic [N_SRC-1:0] irq_overflow,
   output logic             busy
);

   irq_state_e       state_q, state_d;
   logic [N_SRC-1:0] prev_q;
   logic [N_SRC-1:0] pending_q, pending_d;
   logic [N_SRC-1:0] ovf_q, ovf_d;
   logic [ID_W-1:0]  irq_id_q, irq_id_d;
   logic             ext_irq_q, ext_irq_d;
   logic             busy_q, busy_d;

   logic [N_SRC-1:0] rise_vec;
   logic [N_SRC-1:0] clr_vec;
   logic [ID_W-1:0]  enc_idx;
   logic             enc_valid;

   irq_prio_enc #(
      .N (N_SRC),
      .W (ID_W)
   ) u_prio_enc (
      .req   (pending_q & ~irq_mask),
      .idx   (enc_idx),
      .valid (enc_valid)
   );

   always_ff @(posedge clk) begin
      // prev_q tracks irq_src even in reset so lines held high never look like a fresh edge
      prev_q <= irq_src;
      if (reset) begin
         state_q   <= ST_IDLE;
         pending_q <= '0;
         ovf_q     <= '0;
         irq_id_q  <= '0;
         ext_irq_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         ovf_q     <= ovf_d;
         irq_id_q  <= irq_id_d;
         ext_irq_q <= ext_irq_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (enc_valid) state_d = ST_REQ;
         ST_REQ:     if (ExtIAck)   state_d = ST_SERVICE;
         ST_SERVICE: if (ERet)      state_d = ST_IDLE;
         default:                   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      irq_id_d = irq_id_q;
      if (state_q == ST_IDLE && enc_valid) begin
         irq_id_d = enc_idx;
      end
      ext_irq_d = (state_d == ST_REQ);
      busy_d    = (state_d != ST_IDLE);
   end

   // A new edge always wins over the acknowledge clear of the same bit
   always_comb begin
      rise_vec = irq_src & ~prev_q;
      clr_vec  = '0;
      for (int i = 0; i < N_SRC; i++) begin
         clr_vec[i] = (state_q == ST_REQ) && ExtIAck && (irq_id_q == ID_W'(i));
      end
      pending_d = (pending_q & ~clr_vec) | rise_vec;
      ovf_d     = ovf_q | (rise_vec & pending_q & ~clr_vec);
   end

   assign ExtIRQ       = ext_irq_q;
   assign irq_id       = irq_id_q;
   assign pending      = pending_q;
   assign irq_overflow = ovf_q;
   assign busy         = busy_q;

endmodule
